// File: rtl/fft_pkg.sv
// fft_pkg: shared state enum, default sizes and address helpers for the FFT sequencer
// Contents: seq_state_e, LOG2N_DEF, PIPE_LAT_DEF, bit_reverse(), insert_zero()
// Helpers work on 16-bit values, so LOG2N must not exceed 16.
package fft_pkg;
  localparam int LOG2N_DEF = 10;
  localparam int PIPE_LAT_DEF = 8;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT, S_FIN} seq_state_e;
  function automatic logic [15:0] bit_reverse(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (i < n) r[i] = v[4'(n - 1 - i)];
    return r;
  endfunction
  // Opens a zero at bit p: bits at and above p move up by one.
  function automatic logic [15:0] insert_zero(input logic [15:0] v, input int p);
    logic [15:0] m;
    m = (16'(1) << p) - 16'(1);
    return ((v & ~m) << 1) | (v & m);
  endfunction
endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: combinational butterfly address and twiddle map for one radix-2 DIF stage
// Ports: stage, bfly_idx in; addr_a (upper leg), addr_b (lower leg), twiddle (ROM index) out.
module fft_addr_gen import fft_pkg::*; #(
  parameter int LOG2N = LOG2N_DEF
) (
  input  logic [3:0]       stage,
  input  logic [LOG2N-2:0] bfly_idx,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] twiddle
);
  int p;
  always_comb begin
    p = LOG2N - 1 - int'(stage);
    addr_a = LOG2N'(insert_zero(16'(bfly_idx), p));
    addr_b = addr_a | LOG2N'(16'(1) << p);
    twiddle = (LOG2N-1)'((16'(bfly_idx) & ((16'(1) << p) - 16'(1))) << stage);
  end
endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: butterfly issue scheduler for an in-place radix-2 DIF FFT
// Ports: clock_c, reset_c (async, active high), start, stall in;
//   busy, done, bfly_valid, stage, bfly_idx, addr_a, addr_b, twiddle, last_bfly,
//   rd_valid, rd_addr out (all registered).
// FFT_SEQ_BITREV_EN adds the bit-reversed output read phase; otherwise rd_* are tied to 0.
// Registers hold what the datapath sees next cycle, so stall sampled at an edge
// gates the issue in the following cycle. Entering RUN or OUT always issues.
module fft_stage_sequencer import fft_pkg::*; #(
  parameter int LOG2N = LOG2N_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic             clock_c,
  input  logic             reset_c,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             bfly_valid,
  output logic [3:0]       stage,
  output logic [LOG2N-2:0] bfly_idx,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] twiddle,
  output logic             last_bfly,
  output logic             rd_valid,
  output logic [LOG2N-1:0] rd_addr
);
  localparam int CW = $clog2(PIPE_LAT) + 1;
  localparam logic [3:0] STAGE_LAST = 4'(LOG2N - 1);
`ifdef FFT_SEQ_BITREV_EN
  localparam seq_state_e AFTER_FFT = S_OUT;
`else
  localparam seq_state_e AFTER_FFT = S_FIN;
`endif
  seq_state_e state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [3:0] stage_n;
  logic [LOG2N-2:0] idx_n, tw_n;
  logic [LOG2N-1:0] a_n, b_n;
  logic valid_n, stage_end, drain_end;
  assign stage_end = bfly_valid && bfly_idx == '1;
  assign drain_end = cnt_q == CW'(PIPE_LAT - 1);
`ifdef FFT_SEQ_BITREV_EN
  logic [LOG2N-1:0] k_q, k_n;
  logic rdv_n, out_end;
  assign out_end = rd_valid && k_q == '1;
`endif
  always_ff @(posedge clock_c or posedge reset_c)
    if (reset_c) state_q <= S_IDLE;
    else state_q <= state_n;
  always_comb begin
    state_n = S_IDLE;
    case (state_q)
      S_IDLE:  state_n = start ? S_RUN : S_IDLE;
      S_RUN:   state_n = stage_end ? S_DRAIN : S_RUN;
      S_DRAIN: state_n = !drain_end ? S_DRAIN : stage != STAGE_LAST ? S_RUN : AFTER_FFT;
`ifdef FFT_SEQ_BITREV_EN
      S_OUT:   state_n = out_end ? S_FIN : S_OUT;
`endif
      default: state_n = S_IDLE;
    endcase
  end
  // bfly_idx points at the next butterfly while a stall bubble is shown.
  always_comb begin
    stage_n = stage;
    idx_n = bfly_idx;
    valid_n = 1'b0;
    cnt_n = (state_q == S_DRAIN && state_n == S_DRAIN) ? cnt_q + CW'(1) : '0;
    if (state_n == S_RUN && state_q != S_RUN) begin
      stage_n = state_q == S_DRAIN ? stage + 4'd1 : 4'd0;
      idx_n = '0;
      valid_n = 1'b1;
    end else if (state_n == S_RUN) begin
      idx_n = bfly_idx + (LOG2N-1)'(bfly_valid);
      valid_n = !stall;
    end
  end
  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .stage(stage_n),
    .bfly_idx(idx_n),
    .addr_a(a_n),
    .addr_b(b_n),
    .twiddle(tw_n)
  );
  always_ff @(posedge clock_c or posedge reset_c)
    if (reset_c) begin
      cnt_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      bfly_valid <= 1'b0;
      last_bfly <= 1'b0;
      stage <= '0;
      bfly_idx <= '0;
      addr_a <= '0;
      addr_b <= '0;
      twiddle <= '0;
    end else begin
      cnt_q <= cnt_n;
      busy <= state_n != S_IDLE;
      done <= state_n == S_FIN;
      bfly_valid <= valid_n;
      last_bfly <= valid_n && idx_n == '1;
      stage <= stage_n;
      bfly_idx <= idx_n;
      addr_a <= a_n;
      addr_b <= b_n;
      twiddle <= tw_n;
    end
`ifdef FFT_SEQ_BITREV_EN
  always_comb begin
    k_n = k_q;
    rdv_n = 1'b0;
    if (state_q == S_DRAIN && state_n == S_OUT) begin
      k_n = '0;
      rdv_n = 1'b1;
    end else if (state_q == S_OUT && state_n == S_OUT) begin
      k_n = k_q + LOG2N'(rd_valid);
      rdv_n = !stall;
    end
  end
  always_ff @(posedge clock_c or posedge reset_c)
    if (reset_c) begin
      k_q <= '0;
      rd_valid <= 1'b0;
      rd_addr <= '0;
    end else begin
      k_q <= k_n;
      rd_valid <= rdv_n;
      rd_addr <= LOG2N'(bit_reverse(16'(k_n), LOG2N));
    end
`else
  assign rd_valid = 1'b0;
  assign rd_addr = '0;
`endif
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed runs checked every cycle against a schedule model
module tb_fft_stage_sequencer;
  localparam int LOG2N = 10, PIPE_LAT = 8, H = 512, N = 1024, STG = H + PIPE_LAT;
`ifdef FFT_SEQ_BITREV_EN
  localparam int NRD = N;
`else
  localparam int NRD = 0;
`endif
  localparam int FFT_END = LOG2N * STG;
  localparam int END = FFT_END + NRD;
  logic clock_c = 1'b0, reset_c = 1'b1, start = 1'b0, stall = 1'b0;
  logic busy, done, bfly_valid, last_bfly, rd_valid;
  logic [3:0] stage;
  logic [8:0] bfly_idx, twiddle;
  logic [9:0] addr_a, addr_b, rd_addr;
  int checks = 0, fails = 0, cyc = 0, done_cnt = 0, vcnt = 0, n40 = 0;
  int rdq[$];
  fft_stage_sequencer #(.LOG2N(LOG2N), .PIPE_LAT(PIPE_LAT)) dut (
    .clock_c(clock_c), .reset_c(reset_c), .start(start), .stall(stall),
    .busy(busy), .done(done), .bfly_valid(bfly_valid), .stage(stage),
    .bfly_idx(bfly_idx), .addr_a(addr_a), .addr_b(addr_b), .twiddle(twiddle),
    .last_bfly(last_bfly), .rd_valid(rd_valid), .rd_addr(rd_addr)
  );
  always #5 clock_c = ~clock_c;
  always @(posedge clock_c) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic bit is_bfly(input int x);
    return x < FFT_END && x % STG < H;
  endfunction
  function automatic bit is_rd(input int x);
    return x >= FFT_END && x < END;
  endfunction
  function automatic bit phase_start(input int x);
    return is_bfly(x) ? x % STG == 0 : x == FFT_END;
  endfunction
  function automatic int ea(input int s, input int i);
    int q;
    q = 1 << (LOG2N - 1 - s);
    return (i / q) * 2 * q + i % q;
  endfunction
  function automatic int eb(input int s, input int i);
    return ea(s, i) + (1 << (LOG2N - 1 - s));
  endfunction
  function automatic int etw(input int s, input int i);
    return ((i % (1 << (LOG2N - 1 - s))) * (1 << s)) % H;
  endfunction
  function automatic int rev(input int k);
    int r;
    r = 0;
    for (int j = 0; j < LOG2N; j++) r = r * 2 + (k >> j) % 2;
    return r;
  endfunction
  // Schedule model: m_pos walks the flattened item list (issues, drain slots,
  // reads, then the done slot at END); m_hold marks a stall bubble before m_pos.
  bit m_run, m_hold;
  int m_pos;
  always @(posedge clock_c or posedge reset_c)
    if (reset_c) begin
      m_run <= 1'b0;
      m_hold <= 1'b0;
      m_pos <= 0;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1'b1;
        m_pos <= 0;
        m_hold <= 1'b0;
      end
    end else if (m_pos == END) m_run <= 1'b0;
    else if (m_hold) m_hold <= stall;
    else begin
      m_pos <= m_pos + 1;
      m_hold <= stall && (is_bfly(m_pos + 1) || is_rd(m_pos + 1)) && !phase_start(m_pos + 1);
    end
  always @(negedge clock_c) begin
    bit ev, er;
    int s, i;
    ev = m_run && !m_hold && is_bfly(m_pos);
    er = m_run && !m_hold && is_rd(m_pos);
    s = m_pos / STG;
    i = m_pos % STG;
    chk("busy", busy, m_run);
    chk("done", done, m_run && m_pos == END);
    chk("bfly_valid", bfly_valid, ev);
    chk("last_bfly", last_bfly, ev && i == H - 1);
    chk("rd_valid", rd_valid, er);
    if (ev) begin
      chk("stage", stage, s);
      chk("bfly_idx", bfly_idx, i);
      chk("addr_a", addr_a, ea(s, i));
      chk("addr_b", addr_b, eb(s, i));
      chk("twiddle", twiddle, etw(s, i));
    end
    if (er) chk("rd_addr", rd_addr, rev(m_pos - FFT_END));
    if (bfly_valid && stage == 0 && bfly_idx == 5) begin
      chk("s0i5 addr_a", addr_a, 5);
      chk("s0i5 addr_b", addr_b, 517);
      chk("s0i5 twiddle", twiddle, 5);
    end
    if (bfly_valid && stage == 3 && bfly_idx == 100) begin
      chk("s3i100 addr_a", addr_a, 164);
      chk("s3i100 addr_b", addr_b, 228);
      chk("s3i100 twiddle", twiddle, 288);
    end
    if (bfly_valid && stage == 9 && bfly_idx == 100) begin
      chk("s9i100 addr_a", addr_a, 200);
      chk("s9i100 addr_b", addr_b, 201);
      chk("s9i100 twiddle", twiddle, 0);
    end
    if (bfly_valid) vcnt++;
    if (done) done_cnt++;
    if (bfly_valid && stage == 2 && bfly_idx == 40) n40++;
    if (rd_valid) rdq.push_back(int'(rd_addr));
  end
  task automatic chk_zero(input string nm);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " bfly_valid"}, bfly_valid, 0);
    chk({nm, " last_bfly"}, last_bfly, 0);
    chk({nm, " rd_valid"}, rd_valid, 0);
    chk({nm, " stage"}, stage, 0);
    chk({nm, " bfly_idx"}, bfly_idx, 0);
    chk({nm, " addr_a"}, addr_a, 0);
    chk({nm, " addr_b"}, addr_b, 0);
    chk({nm, " twiddle"}, twiddle, 0);
    chk({nm, " rd_addr"}, rd_addr, 0);
  endtask
  // mode: 0 plain, 1 start re-pulsed while busy, 2 stall x3 at stage 2 idx 40,
  // 3 stall across the whole stage-4 drain, 4 reset during stage 5
  task automatic run(input int mode, input int exp_delta, input string nm);
    int e, d0, v0, n0, left, tgt;
    bit got, fired;
    d0 = done_cnt;
    v0 = vcnt;
    n0 = n40;
    left = 0;
    tgt = -1;
    got = 0;
    fired = 0;
    start = 1'b1;
    @(negedge clock_c);
    start = 1'b0;
    e = cyc;
    for (int t = 0; t < 8000 && !got; t++) begin
      int dl;
      dl = cyc - e + 1;
      start = mode == 1 && dl == 100;
      if (done) begin
        got = 1;
        chk({nm, " done cycle"}, dl, exp_delta);
      end else if (mode == 4 && bfly_valid && stage == 5) begin
        #2 reset_c = 1'b1;
        #1 chk_zero({nm, " async"});
        @(negedge clock_c);
        @(negedge clock_c);
        reset_c = 1'b0;
        got = 1;
      end else begin
        if (mode == 2 && !fired && bfly_valid && stage == 2 && bfly_idx == 40) begin
          left = 3;
          fired = 1;
        end
        if (mode == 3 && !fired && last_bfly && stage == 4) begin
          left = 9;
          tgt = dl + 9;
          fired = 1;
        end
        if (dl == tgt) begin
          chk({nm, " post-drain valid"}, bfly_valid, 1);
          chk({nm, " post-drain stage"}, stage, 5);
          chk({nm, " post-drain idx"}, bfly_idx, 0);
        end
        stall = left > 0;
        if (left > 0) left--;
        @(negedge clock_c);
      end
    end
    stall = 1'b0;
    start = 1'b0;
    if (!got) chk({nm, " timeout"}, 0, 1);
    else if (mode == 4) begin
      repeat (20) @(negedge clock_c);
      chk({nm, " no done"}, done_cnt - d0, 0);
    end else begin
      @(negedge clock_c);
      chk({nm, " busy drop"}, busy, 0);
      repeat (20) @(negedge clock_c);
      chk({nm, " done count"}, done_cnt - d0, 1);
      chk({nm, " valid count"}, vcnt - v0, 5120);
      if (mode == 2) chk({nm, " idx40 issues"}, n40 - n0, 1);
    end
  endtask
  initial begin
    chk("model ea s0i5", ea(0, 5), 5);
    chk("model eb s0i5", eb(0, 5), 517);
    chk("model ea s3i100", ea(3, 100), 164);
    chk("model etw s3i100", etw(3, 100), 288);
    chk("model eb s9i100", eb(9, 100), 201);
    chk("model rev 1", rev(1), 512);
    repeat (2) @(negedge clock_c);
    chk_zero("reset");
    reset_c = 1'b0;
    repeat (2) @(negedge clock_c);
    rdq.delete();
    run(1, 5201 + NRD, "run1");
`ifdef FFT_SEQ_BITREV_EN
    chk("rd count", rdq.size(), N);
    if (rdq.size() == N) begin
      chk("rd 0", rdq[0], 0);
      chk("rd 1", rdq[1], 512);
      chk("rd 2", rdq[2], 256);
      chk("rd 3", rdq[3], 768);
      chk("rd last", rdq[N-1], 1023);
    end
`endif
    run(2, 5204 + NRD, "run2");
    run(3, 5201 + NRD, "run3");
    run(4, 0, "run4");
    run(0, 5201 + NRD, "run5");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
